// File: rtl/udiv_pkg.sv
// Shared types and constants for the sequential restoring divider.
package udiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int W_DEF = 8;
  localparam int L_DEF = 2;

  // All-ones quotient returned for divide-by-zero and overflow results.
  function automatic logic [63:0] sat_quot(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/udiv_step.sv
// One combinational restoring-division iteration: shift {R,Q} left, trial-subtract the divisor.
module udiv_step
  import udiv_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W:0]   r,
  input  logic [W-1:0] q,
  input  logic [W-1:0] divisor,
  output logic [W:0]   r_nxt,
  output logic [W-1:0] q_nxt
);

  logic        [W:0] rs;
  logic signed [W:0] t;

  assign rs = {r[W-1:0], q[W-1]};
  assign t  = signed'(rs - {1'b0, divisor});

  // A set r[W] means the shifted value exceeds any W-bit divisor, so the subtract always succeeds.
  always_comb begin
    r_nxt = rs;
    q_nxt = {q[W-2:0], 1'b0};
    if (r[W] || !t[W]) begin
      r_nxt    = $unsigned(t);
      q_nxt[0] = 1'b1;
    end
  end

endmodule

// File: rtl/udiv_seq_16by8.sv
// Iterative 2W-by-W unsigned restoring divider with valid/ready handshakes on both sides.
// Define UDIV_APPROX_TRUNC_EN to zero the L low dividend bits on accept (truncated approximate division).
module udiv_seq_16by8
  import udiv_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int L = L_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = $clog2(W);
`ifdef UDIV_APPROX_TRUNC_EN
  localparam int LT = L;
`else
  localparam int LT = 0 * L;
`endif
  localparam logic [2*W-1:0] TRUNC_MASK = ~((2*W)'((64'd1 << LT) - 64'd1));
  localparam logic [W-1:0]   SAT_Q      = W'(sat_quot(W));

  state_t          state;
  logic [W:0]      r_p0;
  logic [W-1:0]    q_p0;
  logic [W-1:0]    dvs_p0;
  logic [CW-1:0]   cnt;
  logic [W:0]      r_nxt;
  logic [W-1:0]    q_nxt;
  logic [2*W-1:0]  dvd;

  assign dvd = dividend & TRUNC_MASK;

  udiv_step #(.W(W)) u_step (
    .r       (r_p0),
    .q       (q_p0),
    .divisor (dvs_p0),
    .r_nxt   (r_nxt),
    .q_nxt   (q_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      cnt         <= '0;
      r_p0        <= '0;
      q_p0        <= '0;
      dvs_p0      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= SAT_Q;
              remainder   <= dvd[W-1:0];
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else if (dvd[2*W-1:W] >= divisor) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= SAT_Q;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
            end else begin
              state  <= BUSY;
              r_p0   <= {1'b0, dvd[2*W-1:W]};
              q_p0   <= dvd[W-1:0];
              dvs_p0 <= divisor;
              cnt    <= '0;
            end
          end
        end
        // BUSY: one restoring step per edge; the last step's result goes straight to the outputs.
        BUSY: begin
          r_p0 <= r_nxt;
          q_p0 <= q_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= q_nxt;
            remainder   <= r_nxt[W-1:0];
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/udiv_seq_16by8.md
Name: udiv_seq_16by8

Overview:
- Iterative restoring unsigned divider. It is the inverse of the 8x8 unsigned multiplier family: it recovers x from z = x*y, and it is the exact golden path used to check approximate-multiplier outputs.
- Takes a 2W-bit dividend and a W-bit divisor through valid/ready handshakes.
- Returns a W-bit quotient and a W-bit remainder after W iteration cycles.
- Sits behind the multiplier-evaluation datapath.

Parameters:
- W, 8, operand width (dividend is 2W bits; divisor, quotient and remainder are W bits).
- L, 2, number of low dividend bits forced to zero when the approximate mode is compiled in.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- dividend  input  2W  unsigned dividend, sampled on accept.
- divisor  input  W  unsigned divisor, sampled on accept.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  W  quotient.
- remainder  output  W  remainder.
- div_by_zero  output  1  divisor was 0.
- overflow  output  1  true quotient does not fit in W bits.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, iteration counter=0.
- States:
  - IDLE: in_ready=1. The accept edge is in_valid&&in_ready.
  - BUSY: one iteration per edge.
  - DONE: out_valid=1; outputs stable.
- Accept, div_by_zero precedence: if divisor==0, go to DONE with quotient={W{1}}, remainder=dividend[W-1:0], div_by_zero=1, overflow=0.
- Accept, overflow: else if dividend[2W-1:W] >= divisor, go to DONE with quotient={W{1}}, remainder=0, overflow=1.
- Accept, normal case:
  - Load partial remainder R (W+1 bits) = {0, dividend[2W-1:W]} and Q = dividend[W-1:0].
  - Set counter=0 and enter BUSY.
- BUSY iteration, per edge:
  - {R,Q} shifted left by 1.
  - T = R - {0,divisor}, computed at W+1 bits.
  - If T is non-negative: R=T and Q[0]=1; otherwise Q[0]=0.
  - counter increments.
  - On the edge where counter==W-1, register quotient=Q and remainder=R[W-1:0], clear both flags, and enter DONE.
- Latency, normal case: out_valid rises W+1 edges after the accept edge, counting the accept edge.
- Latency, exception cases: out_valid rises 1 edge after accept.
- DONE: in_ready=0. On out_valid&&out_ready go to IDLE, with in_ready=1 on the next cycle. Results stay held until overwritten by the next completion.
- Throughput: there is no overlap between requests; at most one request per W+2 cycles with out_ready tied high.
- Input stability: dividend and divisor may change after the accept edge without effect.
- Reset mid-operation: rst_n low in any state asynchronously returns all registers to reset values; any in-flight request is dropped.
- Invariant: for normal results, quotient*divisor + remainder == dividend and remainder < divisor.

Optional Feature:
- Macro: UDIV_APPROX_TRUNC_EN.
- When defined: on accept, dividend[L-1:0] is replaced by 0 before every check and the load (truncated-LSB approximate division, matching the lamb-style low-bit pruning). This gives one fewer comparator ripple in the evaluation flow.
- When undefined: exact division; L is ignored.

Decomposition:
- Package udiv_pkg:
  - state enum (IDLE, BUSY, DONE);
  - default W and L localparams;
  - function computing the saturated quotient constant.
- One natural sub-module: udiv_step. It is the combinational single restoring iteration: inputs R, Q, divisor; outputs next R, next Q. It is instantiated once inside the FSM datapath.

Test Plan:
- Basic exact division: dividend=100, divisor=7, out_ready=1 -> quotient=14, remainder=2, flags 0. out_valid exactly 9 edges after accept.
- Max exact case: dividend=65025, divisor=255 -> quotient=255, remainder=0, overflow=0.
- Divide by zero: dividend=0x1234, divisor=0 -> div_by_zero=1, overflow=0, quotient=0xFF, remainder=0x34, out_valid 1 edge after accept.
- Overflow: dividend=0x1234, divisor=0x12 -> overflow=1, quotient=0xFF, remainder=0.
- Backpressure and ordering:
  - 100/7 with out_ready held low 5 cycles -> out_valid and outputs stable, in_ready=0 throughout.
  - Then handshake -> in_ready=1 the next cycle.
  - A second request 200/9 -> quotient=22, remainder=2.
- Reset and approximate mode:
  - Assert rst_n low 3 cycles into BUSY -> all outputs 0 and in_ready=1 immediately.
  - With UDIV_APPROX_TRUNC_EN, L=2: dividend=103, divisor=7 -> quotient=14, remainder=2.
